// File: rtl/matrix_div2x2_seq_if.sv
// rtl/matrix_div2x2_seq_if.sv - operand-in / result-out stream bundle for matrix_div2x2_seq
interface matrix_div2x2_seq_if #(
    parameter int DW = 16,
    parameter int OW = 2*DW+2
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/matrix_div2x2_seq.sv
// rtl/matrix_div2x2_seq.sv - R = A*adj(B) and det(B) on one time-shared signed multiplier
// Optional macro MATRIX_SINGULAR_SKIP_EN: skip MUL/OUT when det(B) == 0.
module matrix_div2x2_seq #(
    parameter int DW = 16,
    parameter int OW = 2*DW+2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    matrix_div2x2_seq_if.slave   bus,
    output logic signed [2*DW:0] det,
    output logic                 det_zero,
    output logic                 busy,
    output logic                 done
);
    localparam int PW = 2*DW+2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DET, S_ADJ, S_MUL, S_OUT, S_DONE
    } state_t;

    state_t                 state_q;
    logic [2:0]             cnt_q;
    logic signed [DW-1:0]   a_q   [4];
    logic signed [DW-1:0]   b_q   [4];
    logic signed [DW:0]     adj_q [4];
    logic signed [PW-1:0]   acc_q;
    logic signed [OW-1:0]   r_q   [4];
    logic signed [2*DW:0]   det_q;
    logic                   det_zero_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic signed [OW-1:0]   out_data_q;
    logic                   out_last_q;

    logic signed [DW:0]     mul_a;
    logic signed [DW:0]     mul_b;
    logic signed [PW-1:0]   prod;

    // Step k of MUL: row i = k[2], term t = k[0], column j = k[1]; a[i][t] * adj[t][j]
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_DET: begin
                if (!cnt_q[0]) begin
                    mul_a = {b_q[0][DW-1], b_q[0]};
                    mul_b = {b_q[3][DW-1], b_q[3]};
                end else begin
                    mul_a = {b_q[1][DW-1], b_q[1]};
                    mul_b = {b_q[2][DW-1], b_q[2]};
                end
            end
            S_MUL: begin
                mul_a = {a_q[{cnt_q[2], cnt_q[0]}][DW-1], a_q[{cnt_q[2], cnt_q[0]}]};
                mul_b = adj_q[{cnt_q[0], cnt_q[1]}];
            end
            default: ;
        endcase
    end

    assign prod = PW'(mul_a) * PW'(mul_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            det_q       <= '0;
            det_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                adj_q[i] <= '0;
                r_q[i]   <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        det_q      <= '0;
                        det_zero_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid && in_ready_q) begin
                        if (!cnt_q[2]) a_q[cnt_q[1:0]] <= bus.in_data;
                        else           b_q[cnt_q[1:0]] <= bus.in_data;
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            in_ready_q <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= S_DET;
                        end
                    end
                end
                S_DET: begin
                    if (!cnt_q[0]) begin
                        acc_q <= prod;
                        cnt_q <= 3'd1;
                    end else begin
                        acc_q   <= acc_q - prod;
                        cnt_q   <= '0;
                        state_q <= S_ADJ;
                    end
                end
                S_ADJ: begin
                    // DW+1 bits so that negating the most negative element stays exact
                    adj_q[0]   <= {b_q[3][DW-1], b_q[3]};
                    adj_q[1]   <= -{b_q[1][DW-1], b_q[1]};
                    adj_q[2]   <= -{b_q[2][DW-1], b_q[2]};
                    adj_q[3]   <= {b_q[0][DW-1], b_q[0]};
                    det_q      <= acc_q[2*DW:0];
                    det_zero_q <= (acc_q == '0);
`ifdef MATRIX_SINGULAR_SKIP_EN
                    if (acc_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_MUL;
                    end
`else
                    state_q <= S_MUL;
`endif
                end
                S_MUL: begin
                    if (!cnt_q[0]) acc_q <= prod;
                    else           r_q[cnt_q[2:1]] <= OW'(acc_q + prod);
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        cnt_q       <= '0;
                        state_q     <= S_OUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= r_q[0];
                        out_last_q  <= 1'b0;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        if (cnt_q == 3'd3) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_q + 3'd1;
                            out_data_q <= r_q[cnt_q[1:0] + 2'd1];
                            out_last_q <= (cnt_q == 3'd2);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign det           = det_q;
    assign det_zero      = det_zero_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_matrix_div2x2_seq.sv
// tb/tb_matrix_div2x2_seq.sv - directed scoreboard bench for matrix_div2x2_seq
module tb_matrix_div2x2_seq;
    localparam int DW = 16;
    localparam int OW = 2*DW+2;
`ifdef MATRIX_SINGULAR_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic signed [2*DW:0] det;
    logic                 det_zero;
    logic                 busy;
    logic                 done;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     done_cnt = 0;
    longint exp_q[$];
    longint a_m[4];
    longint b_m[4];
    longint det_m;

    always #5 clk = ~clk;

    matrix_div2x2_seq_if #(.DW(DW), .OW(OW)) bus ();

    matrix_div2x2_seq #(.DW(DW), .OW(OW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .det      (det),
        .det_zero (det_zero),
        .busy     (busy),
        .done     (done)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic set_case(input longint a0, a1, a2, a3, b0, b1, b2, b3);
        a_m = '{a0, a1, a2, a3};
        b_m = '{b0, b1, b2, b3};
    endtask

    // R = A * adj(B), adj = [b11 -b01; -b10 b00]
    function automatic void predict();
        det_m = b_m[0]*b_m[3] - b_m[1]*b_m[2];
        if (!(SKIP_EN && det_m == 0)) begin
            exp_q.push_back(a_m[0]*b_m[3] - a_m[1]*b_m[2]);
            exp_q.push_back(-a_m[0]*b_m[1] + a_m[1]*b_m[0]);
            exp_q.push_back(a_m[2]*b_m[3] - a_m[3]*b_m[2]);
            exp_q.push_back(-a_m[2]*b_m[1] + a_m[3]*b_m[0]);
        end
    endfunction

    task automatic load(input int n, input bit gaps, input bit poke);
        int n_wait;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 3 == 1)) begin
                bus.in_valid = 1'b0;
                repeat (2) @(negedge clk);
            end
            bus.in_valid = 1'b1;
            if (i < 4) bus.in_data = DW'(a_m[i]);
            else       bus.in_data = DW'(b_m[i-4]);
            if (poke) start = 1'b1;
            n_wait = 0;
            while (bus.in_ready !== 1'b1 && n_wait < 20) begin
                @(negedge clk);
                n_wait++;
            end
            chk("in_ready", bus.in_ready, 1);
            if (i < n-1) @(negedge clk);
        end
    endtask

    task automatic run(input bit gaps, input bit bp, input bit poke);
        int beats, cyc, stall, d0;
        bit have_hold;
        logic [OW-1:0] hold_d;
        logic hold_l;
        logic signed [63:0] e;
        d0 = done_cnt;
        predict();
        bus.out_ready = !bp;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!poke) start = 1'b0;
        chk("det_cleared", det, 0);
        chk("busy_load", busy, 1);
        load(8, gaps, poke);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (SKIP_EN && det_m == 0) begin
            repeat (3) @(negedge clk);
            chk("skip_done_t4", done, 1);
            chk("skip_no_valid", bus.out_valid, 0);
            chk("skip_det_zero", det_zero, 1);
            @(negedge clk);
            start = 1'b0;
            chk("skip_done_clear", done, 0);
            chk("skip_idle", busy, 0);
        end else begin
            repeat (10) @(negedge clk);
            chk("valid_t11", bus.out_valid, 0);
            chk("busy_mul", busy, 1);
            @(negedge clk);
            chk("valid_t12", bus.out_valid, 1);
            chk("det", det, det_m);
            chk("det_zero", det_zero, det_m == 0);
            beats = 0; cyc = 0; stall = 0; have_hold = 0;
            while (beats < 4 && cyc < 100) begin
                if (bus.out_valid === 1'b1) begin
                    if (have_hold) begin
                        chk("hold_data", $signed(bus.out_data), $signed(hold_d));
                        chk("hold_last", bus.out_last, hold_l);
                    end
                    bus.out_ready = !bp || stall == 2;
                    if (bus.out_ready) begin
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'sh7fffffffffffffff;
                        chk("out_data", $signed(bus.out_data), e);
                        chk("out_last", bus.out_last, beats == 3);
                        beats++;
                        stall = 0;
                        have_hold = 0;
                    end else begin
                        stall++;
                        hold_d = bus.out_data;
                        hold_l = bus.out_last;
                        have_hold = 1;
                    end
                end
                @(negedge clk);
                cyc++;
            end
            chk("beat_count", beats, 4);
            chk("done_pulse", done, 1);
            chk("done_no_valid", bus.out_valid, 0);
            chk("done_busy", busy, 1);
            @(negedge clk);
            start = 1'b0;
            chk("done_clear", done, 0);
            chk("idle_busy", busy, 0);
        end
        chk("queue_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("done_once", done_cnt - d0, 1);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_det", det, 0);
        chk("rst_det_zero", det_zero, 0);
        rst_n = 1'b1;

        set_case(1, 2, 3, 4, 2, 1, 1, 1);
        run(0, 0, 0);
        repeat (3) @(negedge clk);
        chk("det_hold_idle", det, 1);

        set_case(1, 2, 3, 4, 2, 4, 1, 2);
        run(0, 0, 0);

        set_case(-32768, -32768, -32768, -32768, -32768, -32768, 0, -32768);
        run(0, 0, 0);

        set_case(1, 2, 3, 4, 2, 1, 1, 1);
        run(1, 1, 0);

        set_case(1, 2, 3, 4, 2, 1, 1, 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load(5, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_data", $signed(bus.out_data), 0);
        chk("mid_rst_out_last", bus.out_last, 0);
        chk("mid_rst_det", det, 0);
        chk("mid_rst_det_zero", det_zero, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(0, 0, 0);

        repeat (2) @(negedge clk);
        chk("det_hold_pre_start", det, 1);
        run(1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/matrix_div2x2_seq.md
Name: matrix_div2x2_seq

Overview:
Parametrised, self-contained successor to the fixed-width 2x2 matrix-divider pipeline. It computes R = A·adj(B) and det(B) exactly, so that A·B⁻¹ = R / det.
- Operands are streamed in over a valid/ready port; results are streamed out over a valid/ready port.
- One shared signed multiplier, time-multiplexed by an internal FSM.
- Sits between the operand-import logic and the result consumer or normaliser.

Parameters:
DW, 16, signed two's-complement width of each A/B element
OW, 2*DW+2, width of each R element on out_data (must be ≥ 2*DW+2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a new operation; sampled only in IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid & in_ready
in_data  in  DW  operand element, signed
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result beat
out_data  out  OW  R element, signed, sign-extended
out_last  out  1  high on the 4th result beat
det  out  2*DW+1  det(B), signed; held until next start
det_zero  out  1  det == 0; held until next start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of operation

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs go to 0, the FSM goes to IDLE and all internal registers clear.
- This applies at any point, including mid-LOAD, mid-MUL or during output backpressure.

FSM states: IDLE, LOAD, DET, ADJ, MUL, OUT, DONE.

IDLE:
- in_ready = 0.
- On start = 1, go to LOAD and clear det/det_zero.
- start in any other state is ignored.

LOAD:
- in_ready = 1.
- Exactly 8 beats are accepted, in this order: a00, a01, a10, a11, b00, b01, b10, b11.
- in_valid gaps stall the load with no timeout.
- On the 8th handshake (cycle T), go to DET.

DET (cycles T+1, T+2):
- p0 = b00·b11, then p1 = b01·b10.
- det = p0 − p1, computed at full 2*DW+1 width with no truncation.

ADJ (cycle T+3):
- adj = [b11, −b01; −b10, b00] at DW+1 bits, so −(−2^(DW−1)) is representable.
- det and det_zero become valid at the end of this cycle.

MUL (cycles T+4 .. T+11):
- 8 products, one per cycle, in order: r00 = a00·adj00 + a01·adj10, r01, r10, r11.
- Each partial sum is accumulated at 2*DW+2 width, with no overflow or saturation.
- Multiplier operands are DW+1 bits signed.

OUT:
- out_valid rises in cycle T+12.
- Beats are r00, r01, r10, r11; out_last is high with r11.
- out_data and out_last are held stable while out_valid & !out_ready.
- On the r11 handshake, go to DONE.

DONE:
- Lasts exactly one cycle with done = 1 and busy = 1, then returns to IDLE.
- A start in the DONE cycle is ignored.

Other rules:
- No backpressure on the input side outside LOAD.
- Input beats are never dropped inside LOAD.
- out_valid is never asserted outside OUT.

Optional Feature:
Macro: MATRIX_SINGULAR_SKIP_EN
- Defined: if det == 0 at the end of ADJ, the block skips MUL and OUT and goes straight to DONE (done in cycle T+4). No result beats are emitted, and det_zero = 1 is held.
- Undefined: det_zero is still reported, but MUL and OUT always run and the 4 R beats are streamed normally.

Test Plan:
1. DW=16, A=[1 2;3 4], B=[2 1;1 1], out_ready=1 -> det=1, det_zero=0, out beats −1, 3, −1, 5 with out_last on the 4th, out_valid first at T+12, done one cycle after the 4th beat.
2. Singular case: A=[1 2;3 4], B=[2 4;1 2] -> det=0, det_zero=1. Without the macro: beats 0, 0, 2, −4. With MATRIX_SINGULAR_SKIP_EN: no out_valid, done at T+4.
3. Extremes: A all −32768, B=[−32768 −32768; 0 −32768] -> det=1073741824, beats 1073741824, 0, 1073741824, 0 (checks the +32768 adj entry).
4. Backpressure: case 1 with out_ready toggled 0,0,1 per beat, plus in_valid gaps during LOAD -> identical values; out_data stable while stalled; exactly 4 beats.
5. Reset mid-operation: assert rst_n=0 after 5 input beats, release, start again with case 1 -> all outputs 0 during reset; second run gives case-1 results with no residue from the aborted load.
6. start pulses during LOAD, MUL and DONE -> ignored; only one done pulse per accepted start; det holds its value through IDLE until the next start.
